// File: rtl/icache_direct_mapped_if.sv
// Instruction-memory refill bus between the cache (master) and instruction memory (slave).
interface icache_direct_mapped_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              mem_read;
  logic [ADDR_W-5:0] mem_address;
  logic [127:0]      mem_readinst;
  logic              mem_busywait;

  modport master (
    output mem_read,
    output mem_address,
    input  mem_readinst,
    input  mem_busywait
  );

  modport slave (
    input  mem_read,
    input  mem_address,
    output mem_readinst,
    output mem_busywait
  );
endinterface

// File: rtl/icache_direct_mapped.sv
// Direct-mapped read-only instruction cache, 16-byte lines, refilled over icache_direct_mapped_if.
// Optional hit/miss counters are built when the ICACHE_STATS_EN macro is defined.
module icache_direct_mapped #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned NUM_BLOCKS  = 8,
  parameter int unsigned BLOCK_WORDS = 4
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic [31:0]                   PC,
  output logic [31:0]                   INSTRUCTION,
  output logic                          BUSYWAIT,
`ifdef ICACHE_STATS_EN
  output logic [15:0]                   hit_count,
  output logic [15:0]                   miss_count,
`endif
  icache_direct_mapped_if.master        mem
);

  localparam int unsigned IdxW = $clog2(NUM_BLOCKS);
  localparam int unsigned BlkW = ADDR_W - 4;
  localparam int unsigned TagW = BlkW - IdxW;

  typedef enum logic [1:0] {
    StIdle,
    StMemRead,
    StUpdate
  } state_e;

  state_e state_q, state_d;

  logic [BlkW-1:0]       miss_addr_q, miss_addr_d;
  logic [NUM_BLOCKS-1:0] valid_q;
  logic [TagW-1:0]       tag_q  [NUM_BLOCKS];
  logic [127:0]          data_q [NUM_BLOCKS];

  logic [BlkW-1:0] pc_blk;
  logic [IdxW-1:0] pc_idx;
  logic [TagW-1:0] pc_tag;
  logic [1:0]      pc_off;
  logic            hit;
  logic            fill_en;
  logic [IdxW-1:0] fill_idx;
  logic [TagW-1:0] fill_tag;
  logic            mem_read;
  logic            unused_pc;

  assign pc_blk    = PC[ADDR_W-1:4];
  assign pc_idx    = PC[4 +: IdxW];
  assign pc_tag    = PC[ADDR_W-1 -: TagW];
  assign pc_off    = PC[3:2];
  assign unused_pc = ^{PC[31:ADDR_W], PC[1:0]};

  assign hit         = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
  assign INSTRUCTION = data_q[pc_idx][{pc_off, 5'b00000} +: 32];

  assign fill_idx = miss_addr_q[IdxW-1:0];
  assign fill_tag = miss_addr_q[BlkW-1 -: TagW];

  assign mem.mem_read    = mem_read;
  assign mem.mem_address = miss_addr_q;

  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    fill_en     = 1'b0;
    mem_read    = 1'b0;
    BUSYWAIT    = 1'b1;
    case (state_q)
      StIdle: begin
        BUSYWAIT = !hit;
        if (!hit) begin
          miss_addr_d = pc_blk;
          state_d     = StMemRead;
        end
      end
      StMemRead: begin
        mem_read = 1'b1;
        if (!mem.mem_busywait) begin
          fill_en = 1'b1;
          state_d = StUpdate;
        end
      end
      StUpdate: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= StIdle;
      miss_addr_q <= '0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      if (fill_en) begin
        valid_q[fill_idx] <= 1'b1;
      end
    end
  end

  // Tag/data arrays carry no reset; a reset in the fill cycle still blocks the write.
  always_ff @(posedge CLK) begin
    if (!RESET && fill_en) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= mem.mem_readinst;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [ADDR_W-3:0] prev_pc_q;
  logic [15:0]       hit_cnt_q;
  logic [15:0]       miss_cnt_q;
  logic              new_pc;

  assign new_pc     = PC[ADDR_W-1:2] != prev_pc_q;
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

  // Stalled repeats of the same PC are not counted as fresh hits.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      prev_pc_q  <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      prev_pc_q <= PC[ADDR_W-1:2];
      if (state_q == StIdle && hit && new_pc && hit_cnt_q != 16'hFFFF) begin
        hit_cnt_q <= hit_cnt_q + 16'd1;
      end
      if (state_q == StIdle && !hit && miss_cnt_q != 16'hFFFF) begin
        miss_cnt_q <= miss_cnt_q + 16'd1;
      end
    end
  end
`endif

  if (BLOCK_WORDS != 4) begin : g_bad_block_words
    $error("BLOCK_WORDS must be 4");
  end

endmodule
